// File: rtl/fetch_queue.sv
// fetch_queue: pipelined instruction fetch with a DEPTH-entry prefetch FIFO and redirect flush
module fetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            stall_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, instr_q, instr_d, pc_q, pc_d, tgt;
  logic [CW-1:0] count_q, count_d, inflight_q, inflight_d, drop_q, drop_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, head;
  logic acc, push, pop, from_rsp;
  assign instr_valid_o = count_q != '0;
  assign imem_req_addr_o = fetch_pc_q;
  assign instr_o = instr_q;
  assign pc_o = pc_q;
  // every issued request reserves a FIFO slot, so pushes are never refused
  always_comb begin
    tgt = redirect_pc_i & ~XLEN'(3);
    imem_req_valid_o = reset_n && !redirect_i && ({1'b0, count_q} + {1'b0, inflight_q} < (CW+1)'(DEPTH));
    acc = imem_req_valid_o && imem_req_ready_i;
    push = imem_rsp_valid_i && drop_q == '0 && !redirect_i;
    pop = instr_valid_o && !stall_i && !redirect_i;
    count_d = redirect_i ? '0 : count_q + CW'(push) - CW'(pop);
    inflight_d = inflight_q + CW'(acc) - CW'(imem_rsp_valid_i);
    drop_d = redirect_i ? inflight_q - CW'(imem_rsp_valid_i) : drop_q - CW'(imem_rsp_valid_i && drop_q != '0);
    fetch_pc_d = redirect_i ? tgt : acc ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    rsp_pc_d = redirect_i ? tgt : push ? rsp_pc_q + XLEN'(4) : rsp_pc_q;
    wr_d = wr_q + PW'(push);
    rd_d = redirect_i ? wr_q : rd_q + PW'(pop);
    head = pop ? rd_q + PW'(1) : rd_q;
    // the next head is the incoming response when the FIFO is, or is about to become, empty
    from_rsp = count_q == '0 || (pop && count_q == CW'(1));
    instr_d = count_d == '0 ? instr_q : from_rsp ? imem_rsp_data_i : instr_mem[head];
    pc_d = count_d == '0 ? pc_q : from_rsp ? rsp_pc_q : pc_mem[head];
  end
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_q] <= imem_rsp_data_i;
      pc_mem[wr_q] <= rsp_pc_q;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      count_q <= '0;
      inflight_q <= '0;
      drop_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      instr_q <= '0;
      pc_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q <= rsp_pc_d;
      count_q <= count_d;
      inflight_q <= inflight_d;
      drop_q <= drop_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      instr_q <= instr_d;
      pc_q <= pc_d;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scoreboard bench with a fixed-latency in-order memory model
module tb_fetch_queue;
  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  logic clk, reset_n, redirect_i, stall_i, req_valid, ready, rsp_valid, instr_valid;
  logic [31:0] redirect_pc, req_addr, rsp_data, instr, pc;
  int total, passed, cyc, lat;
  req_t pend[$];
  logic [31:0] expq[$];

  fetch_queue dut (
    .clk(clk), .reset_n(reset_n), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc),
    .stall_i(stall_i), .imem_req_valid_o(req_valid), .imem_req_ready_i(ready),
    .imem_req_addr_o(req_addr), .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
    .instr_valid_o(instr_valid), .instr_o(instr), .pc_o(pc)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    cyc = 0;
    rsp_valid = 0;
    rsp_data = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!reset_n) begin
        pend.delete();
        rsp_valid = 0;
      end else if (pend.size() > 0 && pend[0].due == cyc) begin
        req_t r;
        r = pend.pop_front();
        rsp_valid = 1;
        rsp_data = ~r.addr;
      end else rsp_valid = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (reset_n && req_valid && ready) pend.push_back('{req_addr, cyc + lat});
  end

  initial forever begin
    @(negedge clk);
    if (reset_n && instr_valid && !stall_i && !redirect_i) begin
      if (expq.size() == 0) chk("unexpected_pop_pc", pc, 32'hxxxxxxxx);
      else begin
        logic [31:0] e;
        e = expq.pop_front();
        chk("pop_pc", pc, e);
        chk("pop_instr", instr, ~e);
      end
    end
  end

  initial begin
    total = 0; passed = 0;
    reset_n = 0; redirect_i = 0; redirect_pc = 0; stall_i = 0; ready = 1; lat = 1;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_instr_valid", {31'b0, instr_valid}, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", pc, 0);
    chk("rst_req_valid", {31'b0, req_valid}, 0);
    // streaming, latency 1
    for (int i = 0; i < 8; i++) expq.push_back(32'(i * 4));
    reset_n = 1;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("t1_req_valid", {31'b0, req_valid}, 1);
      chk("t1_req_addr", req_addr, 32'(k * 4));
      chk("t1_instr_valid", {31'b0, instr_valid}, {31'b0, k >= 2});
      step(1);
      #1;
    end
    ready = 0;
    step(6);
    chk("t1_drained", 32'(expq.size()), 0);
    // stalled fill, latency 3
    reset_n = 0;
    step(2);
    lat = 3; stall_i = 1; ready = 1;
    reset_n = 1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_req_valid", {31'b0, req_valid}, 1);
      chk("t2_req_addr", req_addr, 32'(k * 4));
      step(1);
      #1;
    end
    chk("t2_full_no_req", {31'b0, req_valid}, 0);
    step(3);
    #1;
    chk("t2_full_valid", {31'b0, instr_valid}, 1);
    chk("t2_head_pc", pc, 32'h0);
    chk("t2_head_instr", instr, ~32'h0);
    chk("t2_still_no_req", {31'b0, req_valid}, 0);
    for (int i = 0; i < 5; i++) expq.push_back(32'(i * 4));
    stall_i = 0;
    step(1);
    #1;
    chk("t2_resume_valid", {31'b0, req_valid}, 1);
    chk("t2_resume_addr", req_addr, 32'h10);
    step(1);
    ready = 0;
    step(8);
    chk("t2_drained", 32'(expq.size()), 0);
    // redirect with three in flight, latency 4
    lat = 4; ready = 1;
    #1;
    chk("t3_first_addr", req_addr, 32'h14);
    step(3);
    redirect_i = 1; redirect_pc = 32'h100;
    #1;
    chk("t3_redir_no_req", {31'b0, req_valid}, 0);
    expq.push_back(32'h100); expq.push_back(32'h104);
    step(1);
    redirect_i = 0;
    #1;
    chk("t3_new_req_valid", {31'b0, req_valid}, 1);
    chk("t3_new_req_addr", req_addr, 32'h100);
    step(2);
    ready = 0;
    step(8);
    chk("t3_drained", 32'(expq.size()), 0);
    // redirect coincident with response and pop, latency 2
    lat = 2; ready = 1;
    step(3);
    #1;
    chk("t4_head_valid", {31'b0, instr_valid}, 1);
    chk("t4_head_pc", pc, 32'h108);
    redirect_i = 1; redirect_pc = 32'h100;
    #1;
    chk("t4_redir_no_req", {31'b0, req_valid}, 0);
    expq.push_back(32'h100); expq.push_back(32'h104);
    step(1);
    redirect_i = 0;
    #1;
    chk("t4_flushed", {31'b0, instr_valid}, 0);
    chk("t4_req_valid", {31'b0, req_valid}, 1);
    chk("t4_req_addr", req_addr, 32'h100);
    step(2);
    ready = 0;
    step(8);
    chk("t4_drained", 32'(expq.size()), 0);
    // backpressure holds the request
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t5_hold_valid", {31'b0, req_valid}, 1);
      chk("t5_hold_addr", req_addr, 32'h108);
      step(1);
    end
    ready = 1;
    expq.push_back(32'h108);
    step(1);
    ready = 0;
    #1;
    chk("t5_next_addr", req_addr, 32'h10c);
    chk("t5_next_valid", {31'b0, req_valid}, 1);
    step(6);
    chk("t5_drained", 32'(expq.size()), 0);
    // misaligned redirect target, then async reset mid-burst
    redirect_i = 1; redirect_pc = 32'h203; ready = 1;
    #1;
    chk("t6_redir_no_req", {31'b0, req_valid}, 0);
    expq.push_back(32'h200);
    step(1);
    redirect_i = 0;
    #1;
    chk("t6_aligned_addr", req_addr, 32'h200);
    step(4);
    #1;
    chk("t6_head_valid", {31'b0, instr_valid}, 1);
    chk("t6_head_pc", pc, 32'h204);
    reset_n = 0;
    #1;
    chk("t6_async_valid", {31'b0, instr_valid}, 0);
    chk("t6_async_instr", instr, 0);
    chk("t6_async_pc", pc, 0);
    chk("t6_async_req", {31'b0, req_valid}, 0);
    chk("t6_pre_reset_pops", 32'(expq.size()), 0);
    step(2);
    ready = 1;
    expq.push_back(32'h0);
    reset_n = 1;
    #1;
    chk("t6_restart_valid", {31'b0, req_valid}, 1);
    chk("t6_restart_addr", req_addr, 32'h0);
    step(1);
    ready = 0;
    step(6);
    chk("t6_drained", 32'(expq.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
